// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Groups the control, flag and address signals that run between the
//   decoder/ALU, the program sequencer and the instruction ROM.
//   Parameter L : PC and address width in bits.
//   Ports (seen from the sequencer, i.e. the slave modport):
//     in  Start, StartAddr[L], Stall, Halt, JmpEq, JmpNe, Zero, Rel,
//         Call, Ret, DestAddr[L]
//     out ProgCtr[L], Running, Done, StackErr
//   The master modport is the driving side (decoder or testbench).
interface pc_sequencer_if #(
  parameter int L = 10
);
  logic         Start;
  logic [L-1:0] StartAddr;
  logic         Stall;
  logic         Halt;
  logic         JmpEq;
  logic         JmpNe;
  logic         Zero;
  logic         Rel;
  logic         Call;
  logic         Ret;
  logic [L-1:0] DestAddr;
  logic [L-1:0] ProgCtr;
  logic         Running;
  logic         Done;
  logic         StackErr;

  modport master (
    output Start, StartAddr, Stall, Halt, JmpEq, JmpNe, Zero, Rel,
           Call, Ret, DestAddr,
    input  ProgCtr, Running, Done, StackErr
  );

  modport slave (
    input  Start, StartAddr, Stall, Halt, JmpEq, JmpNe, Zero, Rel,
           Call, Ret, DestAddr,
    output ProgCtr, Running, Done, StackErr
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program sequencer that drives the instruction-ROM address. It has an
//   IDLE/RUN/DONE state machine, absolute or PC-relative branch targets,
//   je/jne condition handling and an optional call/return stack.
//   Parameters: L (PC width), DEPTH (call stack entries; stack build only).
//   Ports:
//     Clk   in  clock, all state changes on posedge
//     Reset in  synchronous active-high reset, highest priority
//     bus   pc_sequencer_if.slave (control inputs, ProgCtr/Running/Done/
//           StackErr outputs)
//   Build option: define PC_CALL_STACK_EN to build the DEPTH-entry
//   call/return stack. Without it Call/Ret are ignored and StackErr is 0.
module pc_sequencer #(
  parameter int L     = 10,
  parameter int DEPTH = 4
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state_reg, state_next;
  logic [L-1:0] pc_reg, pc_next;
  logic [L-1:0] pc_inc;
  logic [L-1:0] target;
  logic         taken;

  // L-bit wrapping arithmetic; DestAddr doubles as a two's-complement offset.
  assign pc_inc = pc_reg + L'(1);
  assign target = bus.Rel ? (pc_reg + bus.DestAddr) : bus.DestAddr;
  // Both JmpEq and JmpNe set makes the branch unconditional.
  assign taken  = (bus.JmpEq & bus.Zero) | (bus.JmpNe & ~bus.Zero);

`ifdef PC_CALL_STACK_EN
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [L-1:0]   stack_mem [DEPTH];
  logic [SPW-1:0] sp_reg, sp_next;
  logic           err_reg, err_next;
  logic           push;
  logic [AW-1:0]  top_idx, wr_idx;
  logic [L-1:0]   stack_top;

  // sp_reg counts valid entries; the top lives at sp_reg-1.
  assign top_idx   = AW'(sp_reg - SPW'(1));
  assign wr_idx    = AW'(sp_reg);
  assign stack_top = stack_mem[top_idx];
`else
  logic unused_call_ret;
  localparam int unused_depth = DEPTH;
  assign unused_call_ret = &{1'b0, bus.Call, bus.Ret};
`endif

  always_comb begin
    pc_next    = pc_reg;
    state_next = state_reg;
`ifdef PC_CALL_STACK_EN
    sp_next    = sp_reg;
    err_next   = err_reg;
    push       = 1'b0;
`endif
    if (bus.Start) begin
      // Start overrides Stall and every RUN action, and restarts from RUN.
      pc_next    = bus.StartAddr;
      state_next = RUN;
`ifdef PC_CALL_STACK_EN
      sp_next    = '0;
      err_next   = 1'b0;
`endif
    end else if (state_reg == RUN && !bus.Stall) begin
      if (bus.Halt) begin
        state_next = DONE;
      end
`ifdef PC_CALL_STACK_EN
      else if (bus.Ret) begin
        if (sp_reg == '0) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          pc_next = stack_top;
          sp_next = sp_reg - SPW'(1);
        end
      end else if (bus.Call) begin
        if (sp_reg == SPW'(DEPTH)) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          push    = 1'b1;
          pc_next = target;
          sp_next = sp_reg + SPW'(1);
        end
      end
`endif
      else if (taken) begin
        pc_next = target;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
`ifdef PC_CALL_STACK_EN
      sp_reg    <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
`ifdef PC_CALL_STACK_EN
      sp_reg    <= sp_next;
      err_reg   <= err_next;
`endif
    end
  end

`ifdef PC_CALL_STACK_EN
  // Stack storage needs no reset: entries above sp_reg are never read.
  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end
  assign bus.StackErr = err_reg;
`else
  assign bus.StackErr = 1'b0;
`endif

  assign bus.ProgCtr = pc_reg;
  assign bus.Running = (state_reg == RUN);
  assign bus.Done    = (state_reg == DONE);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Scoreboard testbench for pc_sequencer (L=10, DEPTH=4). Each stimulus
//   cycle pushes its expected ProgCtr/Running/Done/StackErr; a negedge
//   monitor pops and compares once the DUT edge has happened.
module tb_pc_sequencer;
  logic Clk;
  logic Reset;

  pc_sequencer_if #(.L(10)) bus ();

  pc_sequencer #(.L(10), .DEPTH(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string      tag;
    logic [9:0] pc;
    logic       run;
    logic       done;
    logic       err;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   edge_cnt = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      cur = exp_q.pop_front();
      $display("txn %-12s pc=0x%03h run=%0b done=%0b err=%0b", cur.tag,
               bus.ProgCtr, bus.Running, bus.Done, bus.StackErr);
      check_val({cur.tag, ".pc"},   32'(bus.ProgCtr),  32'(cur.pc));
      check_val({cur.tag, ".run"},  32'(bus.Running),  32'(cur.run));
      check_val({cur.tag, ".done"}, 32'(bus.Done),     32'(cur.done));
      check_val({cur.tag, ".err"},  32'(bus.StackErr), 32'(cur.err));
    end
  end

  task automatic clear_inputs();
    Reset         = 1'b0;
    bus.Start     = 1'b0;
    bus.StartAddr = '0;
    bus.Stall     = 1'b0;
    bus.Halt      = 1'b0;
    bus.JmpEq     = 1'b0;
    bus.JmpNe     = 1'b0;
    bus.Zero      = 1'b0;
    bus.Rel       = 1'b0;
    bus.Call      = 1'b0;
    bus.Ret       = 1'b0;
    bus.DestAddr  = '0;
  endtask

  // Expectation is pushed with the stimulus, then one clock is applied.
  task automatic tick(input string tag, input logic [9:0] pc, input logic run,
                      input logic done, input logic err);
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.run  = run;
    e.done = done;
    e.err  = err;
    e.due  = edge_cnt + 1;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    clear_inputs();
  endtask

  task automatic start_at(input string tag, input logic [9:0] addr);
    bus.Start = 1'b1; bus.StartAddr = addr;
    tick(tag, addr, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic jump_to(input string tag, input logic [9:0] addr);
    bus.JmpEq = 1'b1; bus.JmpNe = 1'b1; bus.DestAddr = addr;
    tick(tag, addr, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    clear_inputs();
    Reset = 1'b1; tick("reset0", 10'h000, 0, 0, 0);
    Reset = 1'b1; tick("reset1", 10'h000, 0, 0, 0);
    bus.JmpNe = 1'b1; bus.DestAddr = 10'h155;
    tick("idle_ign", 10'h000, 0, 0, 0);
    start_at("start40", 10'h040);
    tick("inc41", 10'h041, 1, 0, 0);
    bus.JmpNe = 1'b1; bus.DestAddr = 10'h100;
    tick("jne_tk", 10'h100, 1, 0, 0);
    bus.JmpEq = 1'b1; bus.DestAddr = 10'h300;
    tick("je_nt", 10'h101, 1, 0, 0);
    bus.JmpEq = 1'b1; bus.Zero = 1'b1; bus.DestAddr = 10'h200;
    tick("je_tk", 10'h200, 1, 0, 0);
    bus.JmpNe = 1'b1; bus.Zero = 1'b1; bus.DestAddr = 10'h300;
    tick("jne_nt", 10'h201, 1, 0, 0);
    jump_to("both_jmp", 10'h3FE);
    tick("inc3ff", 10'h3FF, 1, 0, 0);
    tick("wrap0", 10'h000, 1, 0, 0);
    jump_to("abs10", 10'h010);
    bus.Rel = 1'b1; bus.JmpEq = 1'b1; bus.Zero = 1'b1; bus.DestAddr = 10'h3FC;
    tick("rel_m4", 10'h00C, 1, 0, 0);
    bus.Rel = 1'b1; bus.JmpNe = 1'b1; bus.DestAddr = 10'h3F0;
    tick("rel_wrlo", 10'h3FC, 1, 0, 0);
    bus.Rel = 1'b1; bus.JmpNe = 1'b1; bus.DestAddr = 10'h010;
    tick("rel_wrhi", 10'h00C, 1, 0, 0);
    jump_to("abs20", 10'h020);
    bus.Stall = 1'b1; bus.JmpEq = 1'b1; bus.Zero = 1'b1; bus.DestAddr = 10'h2AA;
    tick("stall_jmp", 10'h020, 1, 0, 0);
    bus.Stall = 1'b1; bus.Halt = 1'b1;
    tick("stall_hlt", 10'h020, 1, 0, 0);
    bus.Halt = 1'b1;
    tick("halt", 10'h020, 0, 1, 0);
    bus.JmpNe = 1'b1; bus.DestAddr = 10'h155;
    tick("done_ign", 10'h020, 0, 1, 0);
    bus.Stall = 1'b1;
    start_at("start80", 10'h080);
    bus.Halt = 1'b1; bus.JmpEq = 1'b1; bus.Zero = 1'b1; bus.DestAddr = 10'h111;
    tick("hlt_prio", 10'h080, 0, 1, 0);
    start_at("start54", 10'h054);
    tick("inc55", 10'h055, 1, 0, 0);
    bus.Halt = 1'b1;
    start_at("restart0", 10'h000);
`ifdef PC_CALL_STACK_EN
    jump_to("abs10s", 10'h010);
    bus.Call = 1'b1; bus.DestAddr = 10'h100;
    tick("call100", 10'h100, 1, 0, 0);
    bus.Ret = 1'b1;
    tick("ret011", 10'h011, 1, 0, 0);
    bus.Call = 1'b1; bus.Rel = 1'b1; bus.DestAddr = 10'h00F;
    tick("callrel", 10'h020, 1, 0, 0);
    bus.Ret = 1'b1;
    tick("ret012", 10'h012, 1, 0, 0);
    start_at("start0a", 10'h000);
    bus.Ret = 1'b1;
    tick("ret_empty", 10'h000, 0, 1, 1);
    start_at("start0b", 10'h000);
    bus.Call = 1'b1; bus.DestAddr = 10'h100;
    tick("nest1", 10'h100, 1, 0, 0);
    bus.Call = 1'b1; bus.DestAddr = 10'h200;
    tick("nest2", 10'h200, 1, 0, 0);
    bus.Ret = 1'b1;
    tick("lifo101", 10'h101, 1, 0, 0);
    bus.Ret = 1'b1;
    tick("lifo001", 10'h001, 1, 0, 0);
    bus.Call = 1'b1; bus.DestAddr = 10'h100;
    tick("fill1", 10'h100, 1, 0, 0);
    bus.Call = 1'b1; bus.DestAddr = 10'h200;
    tick("fill2", 10'h200, 1, 0, 0);
    bus.Call = 1'b1; bus.DestAddr = 10'h300;
    tick("fill3", 10'h300, 1, 0, 0);
    bus.Call = 1'b1; bus.DestAddr = 10'h3FF;
    tick("fill4", 10'h3FF, 1, 0, 0);
    bus.Call = 1'b1; bus.DestAddr = 10'h050;
    tick("overflow", 10'h3FF, 0, 1, 1);
    start_at("clr_err", 10'h3FF);
    bus.Call = 1'b1; bus.DestAddr = 10'h050;
    tick("call_wrap", 10'h050, 1, 0, 0);
    bus.Ret = 1'b1; bus.Call = 1'b1; bus.DestAddr = 10'h077;
    tick("ret_prio", 10'h000, 1, 0, 0);
    bus.Halt = 1'b1; bus.Ret = 1'b1;
    tick("hlt_ret", 10'h000, 0, 1, 0);
`else
    bus.Call = 1'b1; bus.DestAddr = 10'h123;
    tick("call_ign", 10'h001, 1, 0, 0);
    bus.Ret = 1'b1;
    tick("ret_ign", 10'h002, 1, 0, 0);
    bus.Call = 1'b1; bus.JmpEq = 1'b1; bus.Zero = 1'b1; bus.DestAddr = 10'h0AA;
    tick("call_br", 10'h0AA, 1, 0, 0);
    bus.Ret = 1'b1; bus.JmpNe = 1'b1; bus.Rel = 1'b1; bus.DestAddr = 10'h006;
    tick("ret_br", 10'h0B0, 1, 0, 0);
`endif
    Reset = 1'b1; bus.Start = 1'b1; bus.StartAddr = 10'h3AB;
    tick("rst_start", 10'h000, 0, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    if (exp_q.size() > 0) check_val("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
